// File: rtl/fpu_pkg.sv
// Shared floating-point constants, rounding modes and the classified-operand
// record used by the FP32 to fixed-point conversion pipeline.
package fpu_pkg;

    localparam int FP32_EXP_W  = 8;
    localparam int FP32_MANT_W = 23;
    localparam int FP32_BIAS   = 127;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } round_mode_t;

    typedef struct packed {
        logic                        sign;
        logic signed [FP32_EXP_W:0]  exp_e;     // unbiased exponent, valid for normals only
        logic [FP32_MANT_W:0]        sig;       // significand with hidden one
        logic                        is_nan;
        logic                        is_inf;
        logic                        is_zero;
        logic                        is_denorm;
    } fp_class_t;

    function automatic fp_class_t fp32_classify(input logic [31:0] f);
        fp_class_t                c;
        logic [FP32_EXP_W-1:0]    e;
        logic [FP32_MANT_W-1:0]   m;
        e           = f[30:23];
        m           = f[22:0];
        c.sign      = f[31];
        c.exp_e     = $signed({1'b0, e}) - $signed((FP32_EXP_W+1)'(FP32_BIAS));
        c.sig       = {1'b1, m};
        c.is_nan    = (e == '1) && (m != '0);
        c.is_inf    = (e == '1) && (m == '0);
        c.is_zero   = (e == '0) && (m == '0);
        c.is_denorm = (e == '0) && (m != '0);
        return c;
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational round / negate / saturate for a W+1 bit unsigned magnitude with
// guard and sticky bits; reusable by any fixed-point narrowing stage.
module fixed_round_sat
    import fpu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W:0]    mag,
    input  logic          g,
    input  logic          st,
    input  logic          sign,
    input  round_mode_t   mode,
    input  logic          pre_ovf,
    output logic [W-1:0]  result,
    output logic          overflow,
    output logic          inexact
);

    localparam logic [W:0] POS_LIM = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0] NEG_LIM = {2'b01, {(W-1){1'b0}}};

    logic       inc;
    logic [W:0] mag_r;
    logic       over_lim;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        inc      = 1'b0;
        mag_r    = '0;
        over_lim = 1'b0;
        overflow = 1'b0;
        inexact  = 1'b0;
        result   = '0;

        case (mode)
            RM_RNE:  inc = g & (st | mag[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & (g | st);
            RM_RDN:  inc = sign & (g | st);
            default: inc = 1'b0;
        endcase

        mag_r    = mag + {{W{1'b0}}, inc};
        // Negative side may reach one step further: -2^(W-1) is representable.
        over_lim = sign ? (mag_r > NEG_LIM) : (mag_r > POS_LIM);
        overflow = pre_ovf | over_lim;
        inexact  = ~overflow & (g | st);

        if (overflow)
            result = sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            result = sign ? -mag_r[W-1:0] : mag_r[W-1:0];
    end

endmodule

// File: rtl/fp32_to_fixed_pipe.sv
// Three-stage FP32 to INT_BITS.FRAC_BITS converter with runtime rounding,
// saturation, special-value handling and a valid/ready stream interface.
module fp32_to_fixed_pipe
    import fpu_pkg::*;
#(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   fp_in,
    input  logic [1:0]                    round_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INT_BITS+FRAC_BITS-1:0] fixed_out,
    output logic                          flag_invalid,
    output logic                          flag_overflow,
    output logic                          flag_inexact
);

    localparam int W  = INT_BITS + FRAC_BITS;
    localparam int MW = W + 1;

    // The whole pipe moves as one: it advances whenever the output slot is free.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack / classify ----------------
    logic        s1_valid;
    fp_class_t   s1_op;
    round_mode_t s1_mode;

    // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (adv)
            s1_valid <= in_valid;
    end

    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_op   <= fp32_classify(fp_in);
            s1_mode <= round_mode_t'(round_mode);
        end
    end

    // ---------------- S2: align / shift ----------------
    int          exp_i;
    int          shift_amt;
    logic [49:0] ext;
    logic [MW-1:0] mag_c;
    logic        g_c;
    logic        st_c;
    logic        pre_ovf_c;
    logic        is_normal;

    always_comb begin
        exp_i     = int'($signed(s1_op.exp_e));
        shift_amt = exp_i + FRAC_BITS - FP32_MANT_W;
        ext       = '0;
        mag_c     = '0;
        g_c       = 1'b0;
        st_c      = 1'b0;
        is_normal = !(s1_op.is_nan || s1_op.is_inf || s1_op.is_zero || s1_op.is_denorm);
        pre_ovf_c = s1_op.is_inf;

        if (is_normal) begin
            // Exactly -2^(INT_BITS-1) is the one in-range value at this exponent.
            pre_ovf_c = (exp_i >= INT_BITS - 1) &&
                        !(s1_op.sign && exp_i == INT_BITS - 1 && s1_op.sig[22:0] == '0);
            if (pre_ovf_c) begin
                mag_c = '0;
            end else if (shift_amt >= 0) begin
                mag_c = MW'(s1_op.sig) << shift_amt;
            end else if (-shift_amt > 25) begin
                st_c = 1'b1;
            end else begin
                ext   = {s1_op.sig, 26'b0} >> (-shift_amt);
                mag_c = MW'(ext[49:26]);
                g_c   = ext[25];
                st_c  = |ext[24:0];
            end
        end
    end

    logic          s2_valid;
    logic          s2_sign;
    logic [MW-1:0] s2_mag;
    logic          s2_g;
    logic          s2_st;
    logic          s2_pre_ovf;
    logic          s2_nan;
    logic          s2_denorm;
    round_mode_t   s2_mode;

    always_ff @(posedge clk) begin
        if (rst)
            s2_valid <= 1'b0;
        else if (adv)
            s2_valid <= s1_valid;
    end

    always_ff @(posedge clk) begin
        if (adv && s1_valid) begin
            s2_sign    <= s1_op.sign;
            s2_mag     <= mag_c;
            s2_g       <= g_c;
            s2_st      <= st_c;
            s2_pre_ovf <= pre_ovf_c;
            s2_nan     <= s1_op.is_nan;
            s2_denorm  <= s1_op.is_denorm;
            s2_mode    <= s1_mode;
        end
    end

    // ---------------- S3: round / negate / saturate ----------------
    logic [W-1:0] rs_result;
    logic         rs_overflow;
    logic         rs_inexact;

    fixed_round_sat #(.W(W)) u_round_sat (
        .mag      (s2_mag),
        .g        (s2_g),
        .st       (s2_st),
        .sign     (s2_sign),
        .mode     (s2_mode),
        .pre_ovf  (s2_pre_ovf),
        .result   (rs_result),
        .overflow (rs_overflow),
        .inexact  (rs_inexact)
    );

    // NaN and denormals arrive with a zero magnitude, so only their flags need patching.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            fixed_out     <= '0;
            flag_invalid  <= 1'b0;
            flag_overflow <= 1'b0;
            flag_inexact  <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                fixed_out     <= rs_result;
                flag_invalid  <= s2_nan;
                flag_overflow <= rs_overflow;
                flag_inexact  <= rs_inexact | s2_denorm;
            end
        end
    end

endmodule
